fifo_64x8: RTL and testbench

- Synchronous single-clock FIFO, 64 entries x 8 bits.
- Used as a generic byte buffer between a producer and a consumer in the same clock domain.
- Write and read are controlled by enables.
- Status is reported through registered-count-derived empty/full flags.

---
 rtl/fifo_64x8_pkg.sv | 9 +
 rtl/fifo_mem_64x8.sv | 33 +++
 rtl/fifo_64x8.sv | 95 +++++++++
 tb/tb_fifo_64x8.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fifo_64x8_pkg.sv
// Shared constants for the 64 x 8 byte FIFO and its storage array.
package fifo_64x8_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int CNT_W  = ADDR_W + 1;

endpackage

// File: rtl/fifo_mem_64x8.sv
// Simple dual-port storage for the byte FIFO: synchronous write, registered read.
// The array itself is never reset; only the read register returns to zero.
module fifo_mem_64x8
    import fifo_64x8_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its value whenever no read is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_64x8.sv
// Single-clock 64 x 8 FIFO with count-decoded empty/full flags.
// Define FIFO64X8_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_64x8
    import fifo_64x8_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_o,
    output logic              empty,
`ifdef FIFO64X8_ERR_FLAGS_EN
    output logic              full,
    output logic              overflow,
    output logic              underflow
`else
    output logic              full
`endif
);

    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              wr_acc;
    logic              rd_acc;

    // Both accept decisions use the flags as they stood at the start of the cycle.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));

    always_comb begin
        count_next = count_reg;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    fifo_mem_64x8 u_mem (
        .clk   (clk),
        .rst_n (reset_n),
        .we    (wr_acc),
        .waddr (wr_ptr_reg),
        .wdata (data_in),
        .re    (rd_acc),
        .raddr (rd_ptr_reg),
        .rdata (data_o)
    );

`ifdef FIFO64X8_ERR_FLAGS_EN
    logic overflow_reg;
    logic underflow_reg;

    // Sticky until the next reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow_reg <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_fifo_64x8.sv
// Directed bench for fifo_64x8 with a byte scoreboard and a reference occupancy model.
// Honours FIFO64X8_ERR_FLAGS_EN when it is defined for the build.
module tb_fifo_64x8;

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_in;
    logic [7:0] data_o;
    logic       empty;
    logic       full;
`ifdef FIFO64X8_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    fifo_64x8 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .data_in   (data_in),
        .data_o    (data_o),
        .empty     (empty),
`ifdef FIFO64X8_ERR_FLAGS_EN
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
`else
        .full      (full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         tests_run;
    int         tests_failed;
    logic [7:0] sb[$];
    int         model_count;
    logic [7:0] model_dout;
    logic       model_ovf;
    logic       model_unf;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data_o"}, data_o, model_dout);
        check({tag, ".empty"}, {7'd0, empty}, {7'd0, model_count == 0});
        check({tag, ".full"}, {7'd0, full}, {7'd0, model_count == 64});
`ifdef FIFO64X8_ERR_FLAGS_EN
        check({tag, ".overflow"}, {7'd0, overflow}, {7'd0, model_ovf});
        check({tag, ".underflow"}, {7'd0, underflow}, {7'd0, model_unf});
`endif
    endtask

    task automatic model_clear();
        sb.delete();
        model_count = 0;
        model_dout  = 8'h00;
        model_ovf   = 1'b0;
        model_unf   = 1'b0;
    endtask

    // Called on a falling edge; drives one cycle and checks the result on the next falling edge.
    task automatic cycle(input string tag, input logic we, input logic re, input logic [7:0] din);
        logic wacc;
        logic racc;
        wr_en   = we;
        rd_en   = re;
        data_in = din;
        wacc = we && (model_count != 64);
        racc = re && (model_count != 0);
        if (we && model_count == 64) model_ovf = 1'b1;
        if (re && model_count == 0) model_unf = 1'b1;
        if (racc) model_dout = sb.pop_front();
        if (wacc) sb.push_back(din);
        model_count = model_count + int'(wacc) - int'(racc);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        model_clear();
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = 8'h00;

        // Reset state
        @(negedge clk);
        check_outputs("reset");
        reset_n = 1'b1;
        cycle("idle", 1'b0, 1'b0, 8'h00);

        // Partial fill and drain
        for (int i = 0; i < 48; i++) cycle("fill48", 1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 48; i++) cycle("drain48", 1'b0, 1'b1, 8'h00);

        // Full, dropped write, drain across pointer wrap
        for (int i = 0; i < 64; i++) cycle("fill64", 1'b1, 1'b0, 8'(i));
        cycle("overflow_wr", 1'b1, 1'b0, 8'hFF);
        for (int i = 0; i < 64; i++) cycle("drain64", 1'b0, 1'b1, 8'h00);

        // Reads on empty hold data_o and leave pointers alone
        cycle("underflow_rd", 1'b0, 1'b1, 8'h00);
        cycle("underflow_rd2", 1'b0, 1'b1, 8'h00);
        cycle("post_unf_wr", 1'b1, 1'b0, 8'hA5);
        cycle("post_unf_rd", 1'b0, 1'b1, 8'h00);

        // Preload then simultaneous traffic through several wraps
        for (int i = 0; i < 10; i++) cycle("preload", 1'b1, 1'b0, 8'(8'h80 + i));
        for (int i = 0; i < 100; i++) cycle("simul", 1'b1, 1'b1, 8'(8'h10 + i));
        for (int i = 0; i < 10; i++) cycle("simul_drain", 1'b0, 1'b1, 8'h00);

        // Both enables on empty: only the write lands
        cycle("empty_both", 1'b1, 1'b1, 8'h55);
        cycle("empty_both_rd", 1'b0, 1'b1, 8'h00);

        // Asynchronous reset while holding 20 entries
        for (int i = 0; i < 21; i++) cycle("load20", 1'b1, 1'b0, 8'(8'hC0 + i));
        cycle("load20_rd", 1'b0, 1'b1, 8'h00);
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        check_outputs("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle("post_rst_wr", 1'b1, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 3; i++) cycle("post_rst_rd", 1'b0, 1'b1, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
